// File: rtl/keypad_display.sv
// keypad_display
// Decodes an externally driven, active-low 4x4 hex keypad and shows the most
// recently accepted key as one hex digit on a common-anode seven-segment
// display (active-low segments and digit enables, both registered).
//
// Optional feature macro: KEYPAD_DEBOUNCE_EN
//   undefined : a valid key is committed on the edge where it is sampled.
//   defined   : a key is committed only after DEBOUNCE_CYCLES consecutive
//               edges with the same valid code.
//
// Valid/commit contract: key_valid is high for a cycle where exactly one row
// line and exactly one column line are low; commit is the single-cycle strobe
// that loads the key register and the display registers, and nothing else
// writes them outside reset.

module keypad_display #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] AN_DIGIT0 = 4'b1110;

    // A zero debounce length would never commit anything.
    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("keypad_display: DEBOUNCE_CYCLES must be at least 1");
    end

    // Index of the single low bit of an active-low line group.
    function automatic logic [1:0] zero_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Hex glyphs, bit order g..a, active-low.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic       key_valid;
    logic [3:0] key_code;
    logic       commit;
    logic [3:0] key_q;
    logic [3:0] key_next;

    // Decode the current row/column sample into a key code and validity.
    always_comb begin
        key_valid = (row inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) &&
                    (col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111});
        key_code  = {zero_index(row), zero_index(col)};
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int         CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    cand_q;
    logic          cand_v_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;

    // Count consecutive edges with an unchanged valid code; restart on any
    // change or on an invalid sample, saturate at the threshold.
    always_comb begin
        cnt_next = CNT_ONE;
        if (key_valid && cand_v_q && (key_code == cand_q)) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
        commit = key_valid && (cnt_next == CNT_MAX);
    end

    // Candidate code and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= 4'h0;
            cand_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cand_q   <= key_code;
            cand_v_q <= key_valid;
            cnt_q    <= cnt_next;
        end
    end
`else
    // Without debounce every valid sample is accepted at once.
    always_comb begin
        commit = key_valid;
    end
`endif

    // Next value of the stored key: new code on commit, otherwise held.
    always_comb begin
        key_next = commit ? key_code : key_q;
    end

    // Key register and display registers; blank until the first commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 4'h0;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
        end else begin
            key_q <= key_next;
            if (commit) begin
                seg <= glyph(key_next);
                an  <= AN_DIGIT0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_display.sv
// Directed bench for keypad_display: reset, full key sweep, hold on release,
// multi-key rejection, asynchronous reset mid-press and, when built with
// KEYPAD_DEBOUNCE_EN, the bounce filter with DEBOUNCE_CYCLES=4.

module tb_keypad_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tab [16];

`ifdef KEYPAD_DEBOUNCE_EN
    keypad_display #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .seg(seg), .an(an)
    );
`else
    keypad_display dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .seg(seg), .an(an)
    );
`endif

    // Clock: 10 time units, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [6:0] exp_seg,
                         input logic [3:0] exp_an);
        checks++;
        assert (seg === exp_seg && an === exp_an) else begin
            errors++;
            $error("FAIL %s: seg=%b an=%b expected seg=%b an=%b",
                   tag, seg, an, exp_seg, exp_an);
        end
    endtask

    // Drive one sample just after an edge, then step to #1 past the next edge.
    task automatic apply(input logic [3:0] r, input logic [3:0] c);
        row = r;
        col = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
        glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
        glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
        glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
        glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
        glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;

`ifdef KEYPAD_DEBOUNCE_EN
        // Reset with no key, release.
        rst_n = 1'b0;
        row   = 4'b1111;
        col   = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("db_reset", 7'b1111111, 4'b1111);
        rst_n = 1'b1;

        // Key 3 bouncing on/off every two clocks never reaches the display.
        for (int k = 0; k < 3; k++) begin
            apply(4'b1110, 4'b0111);
            check("db_bounce_on1", 7'b1111111, 4'b1111);
            apply(4'b1110, 4'b0111);
            check("db_bounce_on2", 7'b1111111, 4'b1111);
            apply(4'b1111, 4'b1111);
            check("db_bounce_off1", 7'b1111111, 4'b1111);
            apply(4'b1111, 4'b1111);
            check("db_bounce_off2", 7'b1111111, 4'b1111);
        end

        // Key 3 held: blank on edges 1..3, glyph on edge 4.
        for (int k = 1; k <= 3; k++) begin
            apply(4'b1110, 4'b0111);
            check("db_hold_wait", 7'b1111111, 4'b1111);
        end
        apply(4'b1110, 4'b0111);
        check("db_hold_commit", 7'b0110000, 4'b1110);
        apply(4'b1110, 4'b0111);
        check("db_hold_stay", 7'b0110000, 4'b1110);
`else
        // Reset held with key 0 present: display stays blank.
        rst_n = 1'b0;
        row   = 4'b1110;
        col   = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        check("reset_blank", 7'b1111111, 4'b1111);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_key0", 7'b1000000, 4'b1110);

        // Sweep all 16 keys row-major.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] rv;
                logic [3:0] cv;
                rv = ~(4'b0001 << r);
                cv = ~(4'b0001 << c);
                apply(rv, cv);
                check($sformatf("sweep_key%0d", 4 * r + c),
                      glyph_tab[4 * r + c], 4'b1110);
            end
        end

        // Key 7 applied: old digit F still shown before the edge.
        row = 4'b1101;
        col = 4'b0111;
        #1;
        check("latency_before_edge", 7'b0001110, 4'b1110);
        @(posedge clk);
        #1;
        check("latency_after_edge", 7'b1111000, 4'b1110);

        // Release: key 7 held for 5 clocks of no key.
        for (int k = 0; k < 5; k++) begin
            apply(4'b1111, 4'b1111);
            check("hold_release", 7'b1111000, 4'b1110);
        end

        // Key 5, then multiple rows / multiple columns / everything low.
        apply(4'b1101, 4'b1101);
        check("key5", 7'b0010010, 4'b1110);
        apply(4'b1100, 4'b1110);
        check("multi_row", 7'b0010010, 4'b1110);
        apply(4'b1110, 4'b1100);
        check("multi_col", 7'b0010010, 4'b1110);
        apply(4'b0000, 4'b0000);
        check("all_low", 7'b0010010, 4'b1110);

        // Key 9 held, async reset pulse between edges.
        apply(4'b1011, 4'b1101);
        check("key9", 7'b0010000, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_blank", 7'b1111111, 4'b1111);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_reset_recapture", 7'b0010000, 4'b1110);

        // After a reset with no key pressed the display stays blank.
        rst_n = 1'b0;
        row   = 4'b1111;
        col   = 4'b1111;
        #1;
        check("reset_nokey_blank", 7'b1111111, 4'b1111);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(4'b1111, 4'b1111);
            check("blank_until_key", 7'b1111111, 4'b1111);
        end
        apply(4'b0111, 4'b1011);
        check("first_key_E", 7'b0000110, 4'b1110);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
